// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add unsigned N x N -> 2N multiplier driving a shared external ALU
module alu_mul_sequencer #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   op_a,
  input  logic [N-1:0]   op_b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic           product_zero,
  output logic [1:0]     alu_m,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  input  logic [N-1:0]   alu_r,
  input  logic           alu_c
);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state;
  logic [N-1:0]   mcand, hi, lo;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] nxt;
  // The ALU carry becomes the new top bit, so full-scale partial sums stay exact.
  assign nxt = {alu_c, alu_r, lo[N-1:1]};
  always_comb begin
    alu_m = 2'b00;
    alu_a = state == RUN ? hi : '0;
    alu_b = (state == RUN && lo[0]) ? mcand : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      mcand        <= '0;
      hi           <= '0;
      lo           <= '0;
      cnt          <= '0;
      product      <= '0;
      product_zero <= 1'b1;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mcand <= op_a;
          lo    <= op_b;
          hi    <= '0;
          cnt   <= '0;
          state <= RUN;
          busy  <= 1'b1;
        end
        RUN: begin
          {hi, lo} <= nxt;
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state        <= DONE;
            done         <= 1'b1;
            product      <= nxt;
            product_zero <= nxt == '0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: scoreboard bench for the N=32 and N=8 multiplier instances
module tb_alu_mul_sequencer;
  typedef struct {
    logic [63:0] p;
    int          c;
  } exp_t;
  logic clk = 0, rst_n = 0;
  int cyc = 0, passed = 0, total = 0;
  bit bad_m = 0;
  exp_t q32[$], q8[$];
  logic        start32 = 0, busy32, done32, pz32, c32;
  logic [31:0] a32 = 0, b32 = 0, alu_a32, alu_b32, r32;
  logic [63:0] prod32;
  logic [1:0]  m32, m8;
  logic        start8 = 0, busy8, done8, pz8, c8;
  logic [7:0]  a8 = 0, b8 = 0, alu_a8, alu_b8, r8;
  logic [15:0] prod8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign {c32, r32} = {1'b0, alu_a32} + {1'b0, alu_b32};
  assign {c8, r8}   = {1'b0, alu_a8} + {1'b0, alu_b8};

  alu_mul_sequencer #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .op_a(a32), .op_b(b32),
    .busy(busy32), .done(done32), .product(prod32), .product_zero(pz32),
    .alu_m(m32), .alu_a(alu_a32), .alu_b(alu_b32), .alu_r(r32), .alu_c(c32));
  alu_mul_sequencer #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_a(a8), .op_b(b8),
    .busy(busy8), .done(done8), .product(prod8), .product_zero(pz8),
    .alu_m(m8), .alu_a(alu_a8), .alu_b(alu_b8), .alu_r(r8), .alu_c(c8));

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (m32 != 2'b00 || m8 != 2'b00) bad_m = 1;
    if (rst_n && done32) begin
      if (q32.size() == 0) chk(0, "unexpected_done32", prod32, 0);
      else begin
        automatic exp_t e = q32.pop_front();
        chk(prod32 == e.p, "product32", prod32, e.p);
        chk(pz32 == (e.p == 0), "zero32", 64'(pz32), 64'(e.p == 0));
        chk(cyc == e.c, "latency32", cyc, e.c);
      end
    end
    if (rst_n && done8) begin
      if (q8.size() == 0) chk(0, "unexpected_done8", 64'(prod8), 0);
      else begin
        automatic exp_t e = q8.pop_front();
        chk(64'(prod8) == e.p, "product8", 64'(prod8), e.p);
        chk(pz8 == (e.p == 0), "zero8", 64'(pz8), 64'(e.p == 0));
        chk(cyc == e.c, "latency8", cyc, e.c);
      end
    end
  end

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input bit push);
    int i;
    for (i = 0; i < 200 && busy32; i++) @(negedge clk);
    if (busy32) chk(0, "idle_timeout32", 64'(busy32), 0);
    start32 = 1; a32 = a; b32 = b;
    if (push) q32.push_back('{64'(a) * 64'(b), cyc + 1 + 32});
    @(negedge clk);
    start32 = 0; a32 = $urandom; b32 = $urandom;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    int i;
    for (i = 0; i < 50 && busy8; i++) @(negedge clk);
    if (busy8) chk(0, "idle_timeout8", 64'(busy8), 0);
    start8 = 1; a8 = a; b8 = b;
    q8.push_back('{64'(a) * 64'(b), cyc + 1 + 8});
    @(negedge clk);
    start8 = 0;
  endtask

  initial begin
    int next_acc, waited;
    bit bad_b;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk(busy32 == 0, "reset_busy", 64'(busy32), 0);
    chk(done32 == 0, "reset_done", 64'(done32), 0);
    chk(prod32 == 0, "reset_product", prod32, 0);
    chk(pz32 == 1, "reset_zero", 64'(pz32), 1);
    // basic 3x5 and busy rising right after acceptance
    issue32(3, 5, 1);
    chk(busy32 == 1, "busy_after_start", 64'(busy32), 1);
    // full-scale operands: second iteration produces a carry out of the ALU
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    @(negedge clk);
    chk(alu_a32 == 32'h7FFF_FFFF, "iter1_alu_a", 64'(alu_a32), 64'h7FFF_FFFF);
    chk(alu_b32 == 32'hFFFF_FFFF, "iter1_alu_b", 64'(alu_b32), 64'hFFFF_FFFF);
    chk(c32 == 1, "iter1_alu_c", 64'(c32), 1);
    // zero multiplier gates alu_b off for the whole run
    issue32(32'h1234_5678, 0, 1);
    bad_b = 0;
    repeat (32) begin
      if (alu_b32 != 0) bad_b = 1;
      @(negedge clk);
    end
    chk(!bad_b, "alu_b_zero_run", 64'(bad_b), 0);
    issue32(0, 32'hDEAD_BEEF, 1);
    // start held high, operands changing every cycle
    for (int i = 0; i < 200 && busy32; i++) @(negedge clk);
    next_acc = cyc + 1;
    for (int k = 0; k < 3 * 34; k++) begin
      start32 = 1;
      a32 = 32'h1000 + 32'(k) * 7;
      b32 = 32'(k) * 3 + 1;
      if (cyc + 1 == next_acc) begin
        q32.push_back('{64'(a32) * 64'(b32), next_acc + 32});
        next_acc += 34;
      end
      @(negedge clk);
    end
    start32 = 0;
    // reset in the middle of a run discards it
    issue32(7, 9, 0);
    repeat (9) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk(busy32 == 0, "midrun_reset_busy", 64'(busy32), 0);
    chk(done32 == 0, "midrun_reset_done", 64'(done32), 0);
    chk(prod32 == 0, "midrun_reset_product", prod32, 0);
    chk(pz32 == 1, "midrun_reset_zero", 64'(pz32), 1);
    repeat (40) @(negedge clk);
    issue32(7, 9, 1);
    // N=8 instance: full scale then random pairs
    issue8(8'hFF, 8'hFF);
    issue8(0, 8'h5A);
    for (int i = 0; i < 1000; i++) issue8(8'($urandom), 8'($urandom));
    waited = 0;
    while ((q32.size() != 0 || q8.size() != 0) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk(q32.size() == 0, "drain32", q32.size(), 0);
    chk(q8.size() == 0, "drain8", q8.size(), 0);
    chk(!bad_m, "alu_mode_add", 64'(bad_m), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
